// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings, idle line level and parity helper for uart_trx
package uart_pkg;
  localparam logic IDLE_LVL = 1'b1;
  localparam int BW = 3;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_DONE} rx_state_e;
  function automatic logic parity_f(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
endpackage

// File: rtl/uart_trx_rx.sv
// uart_trx_rx: synchronised, glitch-rejecting UART receiver with parity/frame error flags
module uart_trx_rx
  import uart_pkg::*;
#(
  parameter int clks_per_bit = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 line,
  output logic [DATA_BITS-1:0] data,
  output logic                 received,
  output logic                 parity_err,
  output logic                 frame_err
);
  localparam int CW = $clog2(2 * clks_per_bit);
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, dout_q, dout_d;
  logic s1_q, s2_q, prev_q, par_q, par_d, fe_q, fe_d, blk_q, blk_d;
  logic perr_q, perr_d, ferr_q, ferr_d, fe_now;
  logic bit_end;
  assign bit_end = cnt_q == CW'(clks_per_bit - 1);
  assign fe_now = fe_q | ~s2_q;
  assign data = dout_q;
  assign received = state_q == RX_DONE;
  assign parity_err = perr_q;
  assign frame_err = ferr_q;
  // two-flop synchroniser plus previous-sample register for falling-edge detect
  always_ff @(posedge clock or posedge reset)
    if (reset) {s1_q, s2_q, prev_q} <= {3{IDLE_LVL}};
    else {s1_q, s2_q, prev_q} <= {line, s1_q, s2_q};
  // receiver state and datapath registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      fe_q <= 1'b0;
      blk_q <= 1'b0;
      dout_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      par_q <= par_d;
      fe_q <= fe_d;
      blk_q <= blk_d;
      dout_q <= dout_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  // next-state: start detect, mid-bit sampling, break blocking and result capture
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    sh_d = sh_q;
    par_d = par_q;
    fe_d = fe_q;
    blk_d = blk_q;
    dout_d = dout_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (blk_q) begin
          cnt_d = s2_q ? cnt_q + 1'b1 : '0;
          if (s2_q && bit_end) begin
            blk_d = 1'b0;
            cnt_d = '0;
          end
        end else if (prev_q && !s2_q) state_d = RX_START;
      end
      RX_START:
        if (cnt_q == CW'(clks_per_bit / 2 - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          fe_d = 1'b0;
          state_d = s2_q ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (bit_end) begin
          cnt_d = '0;
          sh_d = {s2_q, sh_q[DATA_BITS-1:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
            bit_d = '0;
            state_d = PARITY_EN != 0 ? RX_PARITY : RX_STOP;
          end
        end
      RX_PARITY:
        if (bit_end) begin
          cnt_d = '0;
          par_d = s2_q;
          state_d = RX_STOP;
        end
      RX_STOP:
        if (bit_end) begin
          cnt_d = '0;
          fe_d = fe_now;
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(STOP_BITS - 1)) begin
            state_d = RX_DONE;
            dout_d = sh_q;
            perr_d = (PARITY_EN != 0) && (par_q != parity_f(8'(sh_q), PARITY_ODD != 0));
            ferr_d = fe_now;
          end
        end
      RX_DONE: begin
        cnt_d = '0;
        blk_d = ferr_q;
        state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/uart_trx.sv
// uart_trx: full-duplex UART with inline transmitter, loopback mux and receiver
module uart_trx
  import uart_pkg::*;
#(
  parameter int clks_per_bit = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] Data_in,
  output logic                 busy,
  output logic                 sent,
  output logic                 tx,
  input  logic                 rx,
  input  logic                 loopback,
  output logic [DATA_BITS-1:0] Data_out,
  output logic                 received,
  output logic                 parity_err,
  output logic                 frame_err
);
  localparam int CW = $clog2(2 * clks_per_bit);
  tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic sent_q, sent_d, bit_end, stop_end, rx_line;
  assign bit_end = cnt_q == CW'(clks_per_bit - 1);
  assign stop_end = cnt_q == CW'(STOP_BITS * clks_per_bit - 1);
  assign busy = state_q != TX_IDLE;
  assign sent = sent_q;
  assign rx_line = loopback ? tx : rx;
  // transmitter registers
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= TX_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      sent_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      data_q <= data_d;
      sent_q <= sent_d;
    end
  // transmitter next-state; a request during the sent cycle is dropped
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    data_d = data_q;
    sent_d = 1'b0;
    case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        if (send && !sent_q) begin
          data_d = Data_in;
          state_d = TX_START;
        end
      end
      TX_START:
        if (bit_end) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = TX_DATA;
        end
      TX_DATA:
        if (bit_end) begin
          cnt_d = '0;
          bit_d = bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) state_d = PARITY_EN != 0 ? TX_PARITY : TX_STOP;
        end
      TX_PARITY:
        if (bit_end) begin
          cnt_d = '0;
          state_d = TX_STOP;
        end
      TX_STOP:
        if (stop_end) begin
          cnt_d = '0;
          sent_d = 1'b1;
          state_d = TX_IDLE;
        end
      default: state_d = TX_IDLE;
    endcase
  end
  // serial line level decoded from transmitter state
  always_comb
    tx = state_q == TX_START  ? 1'b0 :
         state_q == TX_DATA   ? data_q[bit_q] :
         state_q == TX_PARITY ? parity_f(8'(data_q), PARITY_ODD != 0) : IDLE_LVL;
  uart_trx_rx #(
    .clks_per_bit(clks_per_bit),
    .DATA_BITS   (DATA_BITS),
    .PARITY_EN   (PARITY_EN),
    .PARITY_ODD  (PARITY_ODD),
    .STOP_BITS   (STOP_BITS)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .line      (rx_line),
    .data      (Data_out),
    .received  (received),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );
endmodule

// File: tb/tb_uart_trx.sv
// tb_uart_trx: directed scoreboard bench for uart_trx (4 clks/bit, 8E1)
module tb_uart_trx;
  typedef struct {logic [7:0] d; logic pe; logic fe;} exp_t;
  logic clock = 1'b0, reset = 1'b1, send = 1'b0, rx = 1'b1, loopback = 1'b0;
  logic [7:0] Data_in = 8'h00;
  logic busy, sent, tx, received, parity_err, frame_err;
  logic [7:0] Data_out;
  exp_t sb[$];
  int errors = 0, checks = 0, sent_cnt = 0, rcv_cnt = 0, base;
  uart_trx #(
    .clks_per_bit(4),
    .DATA_BITS   (8),
    .PARITY_EN   (1),
    .PARITY_ODD  (0),
    .STOP_BITS   (1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .send      (send),
    .Data_in   (Data_in),
    .busy      (busy),
    .sent      (sent),
    .tx        (tx),
    .rx        (rx),
    .loopback  (loopback),
    .Data_out  (Data_out),
    .received  (received),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // scoreboard: every received pulse must match the oldest expected frame
  always @(negedge clock) begin
    if (sent) sent_cnt++;
    if (received) begin
      rcv_cnt++;
      chk("rx_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("rx_data", 32'(Data_out), 32'(e.d));
        chk("rx_parity_err", 32'(parity_err), 32'(e.pe));
        chk("rx_frame_err", 32'(frame_err), 32'(e.fe));
      end
    end
  end
  task automatic tx_frame(input logic [7:0] d);
    logic [10:0] pat;
    pat = {1'b1, ^d, d, 1'b0};
    sb.push_back('{d, 1'b0, 1'b0});
    @(posedge clock); #1 send = 1'b1; Data_in = d;
    @(posedge clock); #1 send = 1'b0;
    for (int i = 0; i < 44; i++) begin
      @(negedge clock);
      chk("tx_bit", 32'(tx), 32'(pat[i/4]));
      chk("tx_busy", 32'(busy), 32'd1);
      chk("tx_no_early_sent", 32'(sent), 32'd0);
    end
    @(negedge clock);
    chk("tx_sent_44", 32'(sent), 32'd1);
    chk("tx_idle_44", 32'(busy), 32'd0);
  endtask
  task automatic rx_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] pat;
    pat = {s, p, d, 1'b0};
    sb.push_back('{d, p != ^d, !s});
    @(posedge clock); #1;
    for (int i = 0; i < 11; i++) begin
      rx = pat[i];
      repeat (4) @(posedge clock);
      #1;
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
    chk("rx_drain", 32'(sb.size()), 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge clock);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sent", 32'(sent), 32'd0);
    chk("rst_received", 32'(received), 32'd0);
    chk("rst_data_out", 32'(Data_out), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    loopback = 1'b1;
    tx_frame(8'hA5);
    drain();
    base = sent_cnt;
    sb.push_back('{8'h3C, 1'b0, 1'b0});
    @(posedge clock); #1 send = 1'b1; Data_in = 8'h3C;
    @(posedge clock); #1 send = 1'b0;
    repeat (10) @(posedge clock);
    #1 send = 1'b1; Data_in = 8'hFF;
    @(posedge clock); #1 send = 1'b0;
    for (int i = 0; i < 60 && !sent; i++) begin
      @(posedge clock); #1;
    end
    chk("sent_seen", 32'(sent), 32'd1);
    send = 1'b1;
    @(posedge clock); #1 send = 1'b0;
    @(negedge clock);
    chk("send_on_sent_ignored", 32'(busy), 32'd0);
    repeat (60) @(negedge clock);
    chk("one_sent_pulse", 32'(sent_cnt - base), 32'd1);
    drain();
    loopback = 1'b0;
    rx_frame(8'h81, 1'b1, 1'b1);
    repeat (10) @(posedge clock);
    drain();
    base = rcv_cnt;
    rx_frame(8'h55, 1'b0, 1'b0);
    repeat (40) @(posedge clock);
    #1 chk("break_frame_err", 32'(frame_err), 32'd1);
    rx = 1'b1;
    repeat (2) @(posedge clock);
    #1 rx = 1'b0;
    repeat (8) @(posedge clock);
    #1 chk("break_blocked", 32'(rcv_cnt - base), 32'd1);
    rx = 1'b1;
    repeat (10) @(posedge clock);
    rx_frame(8'h5A, 1'b0, 1'b1);
    repeat (10) @(posedge clock);
    drain();
    base = rcv_cnt;
    #1 rx = 1'b0;
    @(posedge clock); #1 rx = 1'b1;
    repeat (30) @(negedge clock);
    chk("glitch_no_rx", 32'(rcv_cnt - base), 32'd0);
    chk("glitch_data", 32'(Data_out), 32'h5A);
    chk("glitch_perr", 32'(parity_err), 32'd0);
    chk("glitch_ferr", 32'(frame_err), 32'd0);
    base = sent_cnt;
    @(posedge clock); #1 send = 1'b1; Data_in = 8'h86;
    @(posedge clock); #1 send = 1'b0;
    repeat (21) @(negedge clock);
    chk("mid_frame_tx", 32'(tx), 32'd0);
    chk("mid_frame_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1 chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (50) @(negedge clock);
    chk("rst_no_sent", 32'(sent_cnt - base), 32'd0);
    loopback = 1'b1;
    tx_frame(8'h86);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/uart_trx.md
Name: uart_trx

Overview:
- Parametrised full-duplex UART transceiver: one transmitter, one receiver, one shared clock domain.
- Adds configurable data width, optional parity, 1 or 2 stop bits, receive error flags, a glitch-rejecting start-bit detector and a runtime internal loopback.
- Replaces separately instantiated Tx/Rx pairs at the top level and drives or samples the physical serial pins.

Parameters:
- clks_per_bit, 16, clock cycles per serial bit; legal range is 4 or more, even.
- DATA_BITS, 8, payload bits per frame; legal values 5 to 8.
- PARITY_EN, 0, 1 inserts and checks a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- send  in  1  single-cycle request to transmit Data_in.
- Data_in  in  DATA_BITS  transmit payload.
- busy  out  1  transmitter occupied.
- sent  out  1  one-cycle pulse when a frame has completed.
- tx  out  1  serial output; idle level is 1.
- rx  in  1  serial input; asynchronous to clock.
- loopback  in  1  1 routes tx internally to the receiver and ignores rx.
- Data_out  out  DATA_BITS  last received payload.
- received  out  1  one-cycle pulse when a frame has been received.
- parity_err  out  1  parity mismatch on the last frame.
- frame_err  out  1  a stop bit was sampled as 0 on the last frame.

Behaviour:
- Reset (asynchronous, active-high):
  - tx=1, busy=0, sent=0, received=0.
  - Data_out=0, parity_err=0, frame_err=0.
  - Both FSMs go to IDLE and all counters clear.
  - Reset asserted mid-frame aborts the frame immediately; tx returns to 1 with no sent or received pulse.
- TX FSM: IDLE -> START -> DATA -> PARITY (only when PARITY_EN=1) -> STOP -> IDLE.
  - send=1 in IDLE: Data_in is latched and busy=1 on the next edge; tx=0 starts in that same cycle.
  - Each state holds for clks_per_bit cycles.
  - DATA sends bits LSB first.
  - PARITY bit = XOR of the payload, inverted when PARITY_ODD=1.
  - STOP drives 1 for STOP_BITS*clks_per_bit cycles.
  - In the cycle after the last stop cycle: busy=0 and sent=1 for one cycle.
  - send=1 while busy=1 is ignored, not queued.
  - send in the same cycle that sent pulses is also ignored.
  - Frame length = (1 + DATA_BITS + PARITY_EN + STOP_BITS) * clks_per_bit cycles.
- RX input path:
  - Receiver input = loopback ? tx : rx.
  - The selected line passes through a 2-flop synchroniser; idle reset value is 1.
  - loopback should only change while both FSMs are idle; a change mid-frame gives undefined data but must not hang either FSM.
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> DONE -> IDLE.
  - IDLE: a 1->0 transition on the synchronised line enters START.
  - START: wait clks_per_bit/2 cycles, then re-sample. If the line is 1, treat it as a glitch and return to IDLE with no flags changed.
  - Subsequent bits are sampled every clks_per_bit cycles, i.e. mid-bit.
  - STOP: every stop bit is sampled.
  - DONE lasts 1 cycle:
    - Data_out updates and received=1.
    - parity_err and frame_err update in the same cycle and hold until the next DONE.
  - After a frame_err, the receiver stays IDLE-blocked until the line has been 1 for one full clks_per_bit, so a break does not retrigger.
  - Error frames still deliver Data_out and the received pulse.
  - With PARITY_EN=0, parity_err stays 0.
- TX and RX operate fully independently; simultaneous send and receive is legal.

Decomposition:
- Package uart_pkg:
  - TX and RX state encodings.
  - Parity-compute function (XOR reduce with odd select).
  - Constant for the idle line level.
- Natural sub-modules:
  - uart_trx_rx holds the synchroniser, start detect, sampling counter and error logic.
  - The transmitter stays inline in uart_trx alongside the loopback mux.
- Expected size: about 250 lines total.

Test Plan:
- Common configuration: clks_per_bit=4, DATA_BITS=8, PARITY_EN=1, PARITY_ODD=0, STOP_BITS=1.
- Loopback=1, send 0xA5:
  - tx pattern 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles.
  - sent pulses 44 cycles after busy rises.
  - received pulses with Data_out=0xA5, parity_err=0, frame_err=0.
- Send 0x3C, then send 0xFF while busy: only 0x3C is framed; exactly one sent pulse.
- Drive rx externally with 0x81 but parity bit 1 (even parity expects 0) -> received=1, Data_out=0x81, parity_err=1, frame_err=0.
- Drive rx with 0x55 and stop bit 0 -> frame_err=1. Then hold rx=0 for 40 cycles -> no further received pulse until rx has been 1 for 4 cycles.
- Pulse rx low for 1 cycle on an idle line -> glitch rejected; no received pulse, flags unchanged.
- Assert reset in the 5th data bit of a TX frame -> tx=1 and busy=0 asynchronously; no sent pulse. A send after deassertion produces a correct 44-cycle frame.
